// File: rtl/ic_miss_ctrl.sv
// Instruction-cache miss controller: issues one L2 line request per fetch miss,
// assembles the refill beats, writes the victim way and replays the fetch.
module ic_miss_ctrl #(
  parameter int PADDR_W  = 34,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 6,
  parameter int WAY_N    = 4,
  parameter int LINE_W   = 128,
  parameter int BEAT_W   = 64
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_flush,
  input  logic                                  i_s2_miss_valid,
  input  logic [PADDR_W-1:0]                    i_s2_miss_paddr,
  output logic                                  o_busy,
  output logic                                  o_l2_req_valid,
  input  logic                                  i_l2_req_ready,
  output logic [PADDR_W-1:0]                    o_l2_req_paddr,
  input  logic                                  i_l2_resp_valid,
  input  logic [BEAT_W-1:0]                     i_l2_resp_data,
  output logic                                  o_refill_we,
  output logic [WAY_N-1:0]                      o_refill_way,
  output logic [INDEX_W-1:0]                    o_refill_index,
  output logic [PADDR_W-OFFSET_W-INDEX_W-1:0]   o_refill_tag,
  output logic [LINE_W-1:0]                     o_refill_data,
  output logic                                  o_replay_valid,
  output logic [PADDR_W-1:0]                    o_replay_paddr
);

  localparam int TAG_LOW = OFFSET_W + INDEX_W;
  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VIC_W   = (WAY_N > 1) ? $clog2(WAY_N) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_REPLAY = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               kill_q, kill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VIC_W-1:0]   victim_q, victim_d;
  logic [PADDR_W-1:0] paddr_q;
  logic [LINE_W-1:0]  line_q;
  logic               last_beat;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
  end

  // Address and line storage carry no reset; they are only observed behind strobes.
  always_ff @(posedge i_clk) begin
    if (state_q == S_IDLE && i_s2_miss_valid && !i_flush) begin
      paddr_q <= i_s2_miss_paddr;
    end
    if (state_q == S_WAIT && i_l2_resp_valid) begin
      for (int b = 0; b < BEATS; b++) begin
        if (cnt_q == CNT_W'(b)) begin
          line_q[b*BEAT_W +: BEAT_W] <= i_l2_resp_data;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    cnt_d    = cnt_q;
    victim_d = victim_q;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (i_s2_miss_valid && !i_flush) state_d = S_REQ;
      end
      S_REQ: begin
        if (i_l2_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          kill_d  = i_flush;
        end else if (i_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_flush) kill_d = 1'b1;
        // A killed refill still drains every beat so L2 and this block stay in step.
        if (i_l2_resp_valid) begin
          if (last_beat) begin
            state_d = (kill_q || i_flush) ? S_IDLE : S_WRITE;
            cnt_d   = '0;
            kill_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        victim_d = (victim_q == VIC_W'(WAY_N - 1)) ? '0 : victim_q + VIC_W'(1);
        state_d  = i_flush ? S_IDLE : S_REPLAY;
      end
      S_REPLAY: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (state_q != S_IDLE);
    o_l2_req_valid = (state_q == S_REQ);
    o_refill_we    = (state_q == S_WRITE);
    o_refill_way   = '0;
    if (state_q == S_WRITE) o_refill_way = WAY_N'(1) << victim_q;
    o_replay_valid = (state_q == S_REPLAY) && !i_flush;
  end

  assign o_l2_req_paddr = {paddr_q[PADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign o_refill_index = paddr_q[TAG_LOW-1:OFFSET_W];
  assign o_refill_tag   = paddr_q[PADDR_W-1:TAG_LOW];
  assign o_refill_data  = line_q;
  assign o_replay_paddr = paddr_q;

endmodule

// File: tb/tb_ic_miss_ctrl.sv
// Bench for ic_miss_ctrl: scenario tasks with random addresses/beats, checked
// against an event-level model of request, refill write and replay.
module tb_ic_miss_ctrl;
  localparam int PADDR_W  = 34;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 6;
  localparam int WAY_N    = 4;
  localparam int LINE_W   = 128;
  localparam int BEAT_W   = 64;
  localparam int TAG_W    = PADDR_W - OFFSET_W - INDEX_W;

  logic                 i_clk = 1'b0;
  logic                 i_reset_n = 1'b0;
  logic                 i_flush = 1'b0;
  logic                 i_s2_miss_valid = 1'b0;
  logic [PADDR_W-1:0]   i_s2_miss_paddr = '0;
  logic                 o_busy;
  logic                 o_l2_req_valid;
  logic                 i_l2_req_ready = 1'b0;
  logic [PADDR_W-1:0]   o_l2_req_paddr;
  logic                 i_l2_resp_valid = 1'b0;
  logic [BEAT_W-1:0]    i_l2_resp_data = '0;
  logic                 o_refill_we;
  logic [WAY_N-1:0]     o_refill_way;
  logic [INDEX_W-1:0]   o_refill_index;
  logic [TAG_W-1:0]     o_refill_tag;
  logic [LINE_W-1:0]    o_refill_data;
  logic                 o_replay_valid;
  logic [PADDR_W-1:0]   o_replay_paddr;

  ic_miss_ctrl #(
    .PADDR_W(PADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
    .WAY_N(WAY_N), .LINE_W(LINE_W), .BEAT_W(BEAT_W)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_s2_miss_valid(i_s2_miss_valid), .i_s2_miss_paddr(i_s2_miss_paddr),
    .o_busy(o_busy), .o_l2_req_valid(o_l2_req_valid), .i_l2_req_ready(i_l2_req_ready),
    .o_l2_req_paddr(o_l2_req_paddr), .i_l2_resp_valid(i_l2_resp_valid),
    .i_l2_resp_data(i_l2_resp_data), .o_refill_we(o_refill_we), .o_refill_way(o_refill_way),
    .o_refill_index(o_refill_index), .o_refill_tag(o_refill_tag), .o_refill_data(o_refill_data),
    .o_replay_valid(o_replay_valid), .o_replay_paddr(o_replay_paddr)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int exp_writes = 0;
  int flush_at = -1;
  int bm_lo = -1;
  int bm_hi = -2;
  logic [PADDR_W-1:0] alt_pa = '0;

  typedef struct packed {
    logic [WAY_N-1:0]   way;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [LINE_W-1:0]  data;
    int                 at;
  } wr_t;

  wr_t                wr_q[$];
  logic [PADDR_W-1:0] req_q[$];
  logic [PADDR_W-1:0] rep_q[$];
  int                 rep_cyc_q[$];

  always @(negedge i_clk) begin
    if (o_l2_req_valid && i_l2_req_ready) req_q.push_back(o_l2_req_paddr);
    if (o_refill_we) wr_q.push_back('{way: o_refill_way, idx: o_refill_index,
                                      tag: o_refill_tag, data: o_refill_data, at: cyc});
    if (o_replay_valid) begin
      rep_q.push_back(o_replay_paddr);
      rep_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [PADDR_W-1:0] m_align(input logic [PADDR_W-1:0] pa);
    return (pa >> OFFSET_W) << OFFSET_W;
  endfunction
  function automatic logic [INDEX_W-1:0] m_idx(input logic [PADDR_W-1:0] pa);
    return INDEX_W'(pa >> OFFSET_W);
  endfunction
  function automatic logic [TAG_W-1:0] m_tag(input logic [PADDR_W-1:0] pa);
    return TAG_W'(pa >> (OFFSET_W + INDEX_W));
  endfunction
  function automatic logic [WAY_N-1:0] m_way(input int n);
    return WAY_N'(1) << (n % WAY_N);
  endfunction
  function automatic logic [PADDR_W-1:0] rnd_pa();
    return {2'($urandom_range(0, 3)), $urandom()};
  endfunction
  function automatic logic [BEAT_W-1:0] rnd_beat();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_flush = (flush_at >= 0 && cyc == flush_at);
    if (cyc >= bm_lo && cyc <= bm_hi) begin
      i_s2_miss_valid = 1'b1;
      i_s2_miss_paddr = alt_pa;
    end else begin
      i_s2_miss_valid = 1'b0;
    end
  endtask

  task automatic clear_mon();
    wr_q.delete(); req_q.delete(); rep_q.delete(); rep_cyc_q.delete();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && o_busy; k++) tick();
    if (o_busy) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b still set, required 0 within 40 cycles", o_busy);
    end
  endtask

  // One full miss: optional ready delay, gap between beats, flush at cycle offset
  // foff from the miss cycle, and extra misses presented while busy.
  task automatic refill(input logic [PADDR_W-1:0] pa, input int rdy_dly, input int gap,
                        input logic [BEAT_W-1:0] b0, input logic [BEAT_W-1:0] b1,
                        input int foff, input bit busy_miss, output int c0);
    c0       = cyc;
    flush_at = (foff < 0) ? -1 : c0 + foff;
    bm_lo    = c0 + 1;
    bm_hi    = busy_miss ? c0 + 3 : -2;
    alt_pa   = rnd_pa();
    i_s2_miss_valid = 1'b1;
    i_s2_miss_paddr = pa;
    i_flush  = (foff == 0);
    tick();
    repeat (rdy_dly) tick();
    i_l2_req_ready = 1'b1;
    tick();
    i_l2_req_ready  = 1'b0;
    i_l2_resp_valid = 1'b1;
    i_l2_resp_data  = b0;
    tick();
    i_l2_resp_valid = 1'b0;
    repeat (gap) tick();
    i_l2_resp_valid = 1'b1;
    i_l2_resp_data  = b1;
    tick();
    i_l2_resp_valid = 1'b0;
    wait_idle();
    flush_at = -1;
    bm_hi    = -2;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_chk++; if (o_l2_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", o_l2_req_valid); end
    n_chk++; if (o_refill_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", o_refill_we); end
    n_chk++; if (o_refill_way !== '0) begin n_fail++; $display("FAIL rst_way: got %b want 0", o_refill_way); end
    n_chk++; if (o_replay_valid !== 1'b0) begin n_fail++; $display("FAIL rst_replay: got %b want 0", o_replay_valid); end
    i_reset_n = 1'b1;
    exp_writes = 0;
    tick();
    tick();
  endtask

  task automatic test_basic();
    logic [PADDR_W-1:0] pa;
    logic [BEAT_W-1:0]  b0, b1;
    int c0;
    pa = 34'h1_2345_6788;
    b0 = 64'hAAAA_AAAA_AAAA_AAAA;
    b1 = 64'hBBBB_BBBB_BBBB_BBBB;
    clear_mon();
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", o_busy); end
    refill(pa, 0, 0, b0, b1, -1, 1'b0, c0);
    n_chk++; if (req_q.size() != 1) begin n_fail++; $display("FAIL basic_req_cnt: got %0d want 1", req_q.size()); end
    if (req_q.size() >= 1) begin
      n_chk++; if (req_q[0] !== 34'h1_2345_6780) begin n_fail++; $display("FAIL basic_req_pa: got %h want 123456780", req_q[0]); end
    end
    n_chk++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL basic_wr_cnt: got %0d want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      n_chk++; if (wr_q[0].idx !== 6'h38) begin n_fail++; $display("FAIL basic_idx: got %h want 38", wr_q[0].idx); end
      n_chk++; if (wr_q[0].tag !== 24'h48D159) begin n_fail++; $display("FAIL basic_tag: got %h want 48d159", wr_q[0].tag); end
      n_chk++; if (wr_q[0].way !== 4'b0001) begin n_fail++; $display("FAIL basic_way: got %b want 0001", wr_q[0].way); end
      n_chk++; if (wr_q[0].data !== {b1, b0}) begin n_fail++; $display("FAIL basic_data: got %h want %h", wr_q[0].data, {b1, b0}); end
      n_chk++; if (wr_q[0].at != c0 + 4) begin n_fail++; $display("FAIL basic_wr_cyc: got %0d want %0d", wr_q[0].at - c0, 4); end
    end
    n_chk++; if (rep_q.size() != 1) begin n_fail++; $display("FAIL basic_rep_cnt: got %0d want 1", rep_q.size()); end
    if (rep_q.size() >= 1) begin
      n_chk++; if (rep_q[0] !== pa) begin n_fail++; $display("FAIL basic_rep_pa: got %h want %h", rep_q[0], pa); end
      n_chk++; if (rep_cyc_q[0] != c0 + 5) begin n_fail++; $display("FAIL basic_rep_cyc: got %0d want 5", rep_cyc_q[0] - c0); end
    end
    exp_writes++;
  endtask

  task automatic test_ready_stall();
    logic [PADDR_W-1:0] pa;
    logic [BEAT_W-1:0]  b0, b1;
    int c0;
    pa = rnd_pa(); b0 = rnd_beat(); b1 = rnd_beat();
    clear_mon();
    c0 = cyc;
    i_s2_miss_valid = 1'b1;
    i_s2_miss_paddr = pa;
    tick();
    i_s2_miss_paddr = ~pa;
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (o_l2_req_valid !== 1'b1 || o_l2_req_paddr !== m_align(pa)) begin
        n_fail++;
        $display("FAIL stall_req_c%0d: got v=%b pa=%h want v=1 pa=%h", k, o_l2_req_valid, o_l2_req_paddr, m_align(pa));
      end
      tick();
    end
    i_l2_req_ready = 1'b1;
    tick();
    i_l2_req_ready  = 1'b0;
    i_l2_resp_valid = 1'b1; i_l2_resp_data = b0;
    tick();
    i_l2_resp_data = b1;
    tick();
    i_l2_resp_valid = 1'b0;
    wait_idle();
    n_chk++; if (req_q.size() != 1) begin n_fail++; $display("FAIL stall_req_cnt: got %0d want 1", req_q.size()); end
    n_chk++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL stall_wr_cnt: got %0d want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      n_chk++; if (wr_q[0].way !== m_way(exp_writes)) begin n_fail++; $display("FAIL stall_way: got %b want %b", wr_q[0].way, m_way(exp_writes)); end
      n_chk++; if (wr_q[0].data !== {b1, b0}) begin n_fail++; $display("FAIL stall_data: got %h want %h", wr_q[0].data, {b1, b0}); end
    end
    n_chk++; if (rep_q.size() != 1) begin n_fail++; $display("FAIL stall_rep_cnt: got %0d want 1", rep_q.size()); end
    if (rep_q.size() >= 1) begin
      n_chk++; if (rep_cyc_q[0] != c0 + 15) begin n_fail++; $display("FAIL stall_rep_cyc: got %0d want 15", rep_cyc_q[0] - c0); end
    end
    exp_writes++;
  endtask

  task automatic test_flush();
    int f_off[8] = '{0, 1, 1, 2, 3, 3, 4, 5};
    int f_rdy[8] = '{0, 2, 0, 0, 0, 0, 0, 0};
    int f_gap[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int e_req[8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    int e_wr[8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    logic [PADDR_W-1:0] pa;
    logic [BEAT_W-1:0]  b0, b1;
    int c0;
    for (int t = 0; t < 8; t++) begin
      pa = rnd_pa(); b0 = rnd_beat(); b1 = rnd_beat();
      clear_mon();
      refill(pa, f_rdy[t], f_gap[t], b0, b1, f_off[t], 1'b0, c0);
      n_chk++; if (req_q.size() != e_req[t]) begin n_fail++; $display("FAIL flush%0d_req_cnt: got %0d want %0d", t, req_q.size(), e_req[t]); end
      n_chk++; if (wr_q.size() != e_wr[t]) begin n_fail++; $display("FAIL flush%0d_wr_cnt: got %0d want %0d", t, wr_q.size(), e_wr[t]); end
      n_chk++; if (rep_q.size() != 0) begin n_fail++; $display("FAIL flush%0d_rep_cnt: got %0d want 0", t, rep_q.size()); end
      if (e_wr[t] == 1 && wr_q.size() >= 1) begin
        n_chk++; if (wr_q[0].way !== m_way(exp_writes)) begin n_fail++; $display("FAIL flush%0d_way: got %b want %b", t, wr_q[0].way, m_way(exp_writes)); end
        n_chk++; if (wr_q[0].data !== {b1, b0}) begin n_fail++; $display("FAIL flush%0d_data: got %h want %h", t, wr_q[0].data, {b1, b0}); end
      end
      exp_writes += e_wr[t];
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [PADDR_W-1:0] pa;
    logic [BEAT_W-1:0]  b0, b1;
    int c0;
    pa = rnd_pa(); b0 = rnd_beat(); b1 = rnd_beat();
    clear_mon();
    i_s2_miss_valid = 1'b1; i_s2_miss_paddr = pa;
    tick();
    i_l2_req_ready = 1'b1;
    tick();
    i_l2_req_ready = 1'b0;
    i_l2_resp_valid = 1'b1; i_l2_resp_data = b0;
    tick();
    i_l2_resp_valid = 1'b0;
    i_reset_n = 1'b0;
    #1;
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy: got %b want 0", o_busy); end
    n_chk++; if (o_l2_req_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_req: got %b want 0", o_l2_req_valid); end
    n_chk++; if (o_refill_we !== 1'b0 || o_refill_way !== '0) begin n_fail++; $display("FAIL rstw_we: got we=%b way=%b want 0", o_refill_we, o_refill_way); end
    n_chk++; if (o_replay_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_replay: got %b want 0", o_replay_valid); end
    tick();
    tick();
    i_reset_n = 1'b1;
    exp_writes = 0;
    i_l2_resp_valid = 1'b1; i_l2_resp_data = b1;
    tick();
    i_l2_resp_valid = 1'b0;
    tick();
    tick();
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstw_late_busy: got %b want 0", o_busy); end
    n_chk++; if (wr_q.size() != 0 || rep_q.size() != 0) begin n_fail++; $display("FAIL rstw_late_evt: got wr=%0d rep=%0d want 0", wr_q.size(), rep_q.size()); end
    pa = rnd_pa(); b0 = rnd_beat(); b1 = rnd_beat();
    clear_mon();
    refill(pa, 0, 0, b0, b1, -1, 1'b0, c0);
    n_chk++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL rstw_wr_cnt: got %0d want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      n_chk++; if (wr_q[0].way !== 4'b0001) begin n_fail++; $display("FAIL rstw_way: got %b want 0001", wr_q[0].way); end
      n_chk++; if (wr_q[0].data !== {b1, b0}) begin n_fail++; $display("FAIL rstw_data: got %h want %h", wr_q[0].data, {b1, b0}); end
    end
    n_chk++; if (rep_q.size() != 1) begin n_fail++; $display("FAIL rstw_rep_cnt: got %0d want 1", rep_q.size()); end
    exp_writes++;
  endtask

  task automatic test_miss_while_busy();
    logic [PADDR_W-1:0] pa;
    logic [BEAT_W-1:0]  b0, b1;
    int c0;
    pa = rnd_pa(); b0 = rnd_beat(); b1 = rnd_beat();
    clear_mon();
    refill(pa, 0, 0, b0, b1, -1, 1'b1, c0);
    n_chk++; if (req_q.size() != 1) begin n_fail++; $display("FAIL busy_req_cnt: got %0d want 1", req_q.size()); end
    if (req_q.size() >= 1) begin
      n_chk++; if (req_q[0] !== m_align(pa)) begin n_fail++; $display("FAIL busy_req_pa: got %h want %h", req_q[0], m_align(pa)); end
    end
    n_chk++; if (rep_q.size() != 1) begin n_fail++; $display("FAIL busy_rep_cnt: got %0d want 1", rep_q.size()); end
    if (rep_q.size() >= 1) begin
      n_chk++; if (rep_q[0] !== pa) begin n_fail++; $display("FAIL busy_rep_pa: got %h want %h", rep_q[0], pa); end
    end
    n_chk++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL busy_wr_cnt: got %0d want 1", wr_q.size()); end
    exp_writes += wr_q.size();
  endtask

  task automatic test_round_robin();
    logic [PADDR_W-1:0] pa;
    logic [BEAT_W-1:0]  b0, b1;
    int c0, rd, gp;
    for (int t = 0; t < 5; t++) begin
      pa = rnd_pa(); b0 = rnd_beat(); b1 = rnd_beat();
      rd = $urandom_range(0, 3);
      gp = $urandom_range(0, 2);
      clear_mon();
      refill(pa, rd, gp, b0, b1, -1, 1'b0, c0);
      n_chk++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL rr%0d_wr_cnt: got %0d want 1", t, wr_q.size()); end
      if (wr_q.size() >= 1) begin
        n_chk++; if (wr_q[0].way !== m_way(exp_writes)) begin n_fail++; $display("FAIL rr%0d_way: got %b want %b", t, wr_q[0].way, m_way(exp_writes)); end
        n_chk++; if (wr_q[0].idx !== m_idx(pa) || wr_q[0].tag !== m_tag(pa)) begin n_fail++; $display("FAIL rr%0d_idx_tag: got %h/%h want %h/%h", t, wr_q[0].idx, wr_q[0].tag, m_idx(pa), m_tag(pa)); end
        n_chk++; if (wr_q[0].data !== {b1, b0}) begin n_fail++; $display("FAIL rr%0d_data: got %h want %h", t, wr_q[0].data, {b1, b0}); end
      end
      n_chk++; if (rep_q.size() != 1) begin n_fail++; $display("FAIL rr%0d_rep_cnt: got %0d want 1", t, rep_q.size()); end
      if (rep_q.size() >= 1) begin
        n_chk++; if (rep_cyc_q[0] != c0 + 5 + rd + gp) begin n_fail++; $display("FAIL rr%0d_rep_cyc: got %0d want %0d", t, rep_cyc_q[0] - c0, 5 + rd + gp); end
      end
      exp_writes++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ready_stall();
    test_flush();
    test_reset_mid_wait();
    test_miss_while_busy();
    test_round_robin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
